// File: rtl/kernel_pkg.sv
// Types and constants shared by the kernel generator and the convolution
// datapath, plus the single restoring-divide step used by kernel_div.
package kernel_pkg;

    localparam int MAX_KERNAL = 7;
    localparam int ACC_W      = 22;
    localparam int SUM_W      = 14;
    localparam int DIV_CYCLES = 22;

    typedef logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] kernel_arr_t;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DIV,
        OUT
    } conv_state_t;

    typedef struct packed {
        logic [SUM_W-1:0] rem;
        logic [ACC_W-1:0] quo;
    } div_step_t;

    // The partial remainder is always below the divisor, so one extra bit
    // is enough to hold the trial value before the compare.
    function automatic div_step_t div_step(input div_step_t cur, input logic [SUM_W-1:0] d);
        logic [SUM_W:0] trial;
        div_step_t      nxt;
        trial   = {cur.rem, cur.quo[ACC_W-1]};
        nxt.quo = {cur.quo[ACC_W-2:0], 1'b0};
        if (trial >= {1'b0, d}) begin
            trial      = trial - {1'b0, d};
            nxt.quo[0] = 1'b1;
        end
        nxt.rem = trial[SUM_W-1:0];
        return nxt;
    endfunction

endpackage

// File: rtl/kernel_conv_if.sv
// Window-in / pixel-out handshake bundle for kernel_conv.
interface kernel_conv_if #(
    parameter int MAX_KERNAL = kernel_pkg::MAX_KERNAL
);

    logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] window;
    logic                                       win_valid;
    logic                                       win_ready;
    logic [7:0]                                 pix_out;
    logic                                       pix_valid;
    logic                                       pix_ready;

    modport master (
        output window, win_valid, pix_ready,
        input  win_ready, pix_out, pix_valid
    );

    modport slave (
        input  window, win_valid, pix_ready,
        output win_ready, pix_out, pix_valid
    );

endinterface

// File: rtl/kernel_div.sv
// Serial restoring divider: quotient of a 22-bit dividend by a 14-bit divisor,
// done rises exactly DIV_CYCLES edges after the start edge (inclusive).
module kernel_div
    import kernel_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] dividend,
    input  logic [SUM_W-1:0] divisor,
    output logic [ACC_W-1:0] quotient,
    output logic             done
);

    div_step_t        step_q;
    div_step_t        cur;
    div_step_t        nxt;
    logic [SUM_W-1:0] div_q;
    logic [4:0]       cnt;
    logic             done_q;

    // The start edge already performs the first step on the raw dividend.
    always_comb begin
        cur = step_q;
        if (start) begin
            cur.rem = '0;
            cur.quo = dividend;
        end
        nxt = div_step(cur, start ? divisor : div_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= '0;
            div_q  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else if (start) begin
            step_q <= nxt;
            div_q  <= divisor;
            cnt    <= 5'(DIV_CYCLES - 1);
            done_q <= 1'b0;
        end else if (cnt != 5'd0) begin
            step_q <= nxt;
            cnt    <= cnt - 5'd1;
            if (cnt == 5'd1) begin
                done_q <= 1'b1;
            end
        end
    end

    assign quotient = step_q.quo;
    assign done     = done_q;

endmodule

// File: rtl/kernel_conv.sv
// Normalised kernel convolution of one pixel neighbourhood: serial MAC, then
// divide by the kernel sum. Define KERNEL_CONV_ROUND_EN for round-half-up.
module kernel_conv
    import kernel_pkg::*;
#(
    parameter int MAX_KERNAL = kernel_pkg::MAX_KERNAL
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] kernel,
    input  logic [$clog2(MAX_KERNAL)-1:0]              kernel_size,
    input  logic                                       kernel_valid,
    kernel_conv_if.slave                               io,
    output logic                                       busy,
    output logic                                       err
);

    localparam int KW = $clog2(MAX_KERNAL);

    conv_state_t state;
    conv_state_t next_state;

    logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] kern_q;
    logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] win_q;
    logic [KW-1:0]    size_q;
    logic [KW-1:0]    row;
    logic [KW-1:0]    col;
    logic [KW-1:0]    last_idx;
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] kernel_sum;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] dividend;
    logic [ACC_W-1:0] quotient;
    logic [15:0]      prod;
    logic [7:0]       pix_q;
    logic             loaded;
    logic             kernel_ok;
    logic             last_tap;
    logic             win_fire;
    logic             div_go;
    logic             div_done;

    always_comb begin
        kernel_sum = '0;
        for (int r = 0; r < MAX_KERNAL; r++) begin
            for (int c = 0; c < MAX_KERNAL; c++) begin
                if (r < int'(kernel_size) && c < int'(kernel_size)) begin
                    kernel_sum = kernel_sum + SUM_W'(kernel[r][c]);
                end
            end
        end
    end

    assign kernel_ok = kernel_size[0] && (int'(kernel_size) <= MAX_KERNAL) && (kernel_sum != '0);
    assign last_idx  = size_q - KW'(1);
    assign last_tap  = (row == last_idx) && (col == last_idx);
    assign win_fire  = io.win_valid && io.win_ready;
    assign prod      = 16'(win_q[row][col]) * 16'(kern_q[row][col]);

`ifdef KERNEL_CONV_ROUND_EN
    assign dividend = acc + ACC_W'(sum_q >> 1);
`else
    assign dividend = acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // div_go masks a stale done left over from the previous divide.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (win_fire)                next_state = MAC;
            MAC:  if (last_tap)                next_state = DIV;
            DIV:  if (div_done && !div_go)     next_state = OUT;
            OUT:  if (io.pix_ready)            next_state = IDLE;
            default:                           next_state = IDLE;
        endcase
    end

    always_comb begin
        io.win_ready = (state == IDLE) && loaded && !err && !kernel_valid;
        io.pix_valid = (state == OUT);
        io.pix_out   = pix_q;
        busy         = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kern_q <= '0;
            win_q  <= '0;
            size_q <= '0;
            sum_q  <= '0;
            loaded <= 1'b0;
            err    <= 1'b0;
            acc    <= '0;
            row    <= '0;
            col    <= '0;
            div_go <= 1'b0;
            pix_q  <= '0;
        end else begin
            div_go <= 1'b0;
            if (state == IDLE && kernel_valid) begin
                kern_q <= kernel;
                size_q <= kernel_size;
                sum_q  <= kernel_sum;
                loaded <= kernel_ok;
                err    <= !kernel_ok;
            end
            if (win_fire) begin
                win_q <= io.window;
                acc   <= '0;
                row   <= '0;
                col   <= '0;
            end
            if (state == MAC) begin
                acc <= acc + ACC_W'(prod);
                if (col == last_idx) begin
                    col <= '0;
                    row <= row + KW'(1);
                end else begin
                    col <= col + KW'(1);
                end
                div_go <= last_tap;
            end
            if (state == DIV && next_state == OUT) begin
                pix_q <= (|quotient[ACC_W-1:8]) ? 8'hFF : quotient[7:0];
            end
        end
    end

    kernel_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_go),
        .dividend (dividend),
        .divisor  (sum_q),
        .quotient (quotient),
        .done     (div_done)
    );

endmodule

// File: doc/kernel_conv.md
KERNEL_CONV -- requirements
Module: kernel_conv

Interface
REQ-001 Parameter MAX_KERNAL, default 7, maximum kernel edge; all kernel/window arrays are MAX_KERNAL x MAX_KERNAL of 8-bit entries.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock, all state changes on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 kernel  in  [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0]  unsigned weights from the kernel-generation stage.
REQ-006 kernel_size  in  [$clog2(MAX_KERNAL)-1:0]  active edge length N.
REQ-007 kernel_valid  in  1  one-cycle pulse (kernel generator done); latch kernel and kernel_size.
REQ-008 window  in  [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0]  pixel neighbourhood, same indexing as kernel.
REQ-009 win_valid / win_ready  in / out  1  window handshake; transfer on edge with both high.
REQ-010 pix_out  out  8  filtered pixel.
REQ-011 pix_valid / pix_ready  out / in  1  result handshake.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 err  out  1  sticky config error flag.

Function
REQ-014 FSM states IDLE, MAC, DIV, OUT; IDLE->MAC on window transfer, MAC->DIV after N*N taps, DIV->OUT after divider done, OUT->IDLE on pix_valid&pix_ready.
REQ-015 kernel_valid sampled in IDLE only; ignored elsewhere.
REQ-016 On latch, kernel_sum (14 bits) = sum of kernel[r][c] for r,c < N, computed during the latch cycle.
REQ-017 Legal N: odd, 1..MAX_KERNAL; illegal N or kernel_sum==0 sets err=1 and clears kernel_loaded.
REQ-018 A later kernel_valid with legal N and nonzero sum clears err and sets kernel_loaded.
REQ-019 win_ready = (state==IDLE) & kernel_loaded & !err & !kernel_valid.
REQ-020 Window latched on transfer; later changes on window do not affect the result.
REQ-021 MAC: one tap per cycle, row-major r then c, acc (22 bits, unsigned) += window[r][c]*kernel[r][c]; acc cleared on transfer.
REQ-022 DIV: 22-cycle serial restoring divide acc / kernel_sum; quotient >255 saturates to 255.
REQ-023 Latency: pix_valid rises exactly N*N+23 cycles after the transfer edge (N*N MAC + 22 DIV + 1 register).
REQ-024 OUT: pix_out and pix_valid held stable until pix_ready; no new window accepted before OUT exits.
REQ-025 Back-to-back: pix transfer edge returns to IDLE; earliest next window transfer is the following edge.

Reset
REQ-026 On rst: state=IDLE, pix_out=0, pix_valid=0, win_ready=0, busy=0, err=0, acc=0, kernel_loaded=0, latched kernel/sum=0.
REQ-027 rst mid-MAC/DIV/OUT aborts the operation; no partial result is ever presented.

Configuration
REQ-028 Macro KERNEL_CONV_ROUND_EN defined: dividend = acc + (kernel_sum>>1) (round half up); undefined: dividend = acc (truncate). Latency identical.

Structure
REQ-029 Package kernel_pkg holds MAX_KERNAL, the kernel/window array typedef, state enum, and ACC_W=22 / SUM_W=14 constants; shared with the kernel generator.
REQ-030 One sub-module, kernel_div: start/done serial restoring divider, 22-bit dividend, 14-bit divisor, fixed 22-cycle latency.

Verification
REQ-031 3x3 all-ones kernel, window all 100 -> pix_out=100, pix_valid at transfer+32 cycles.
REQ-032 3x3 kernel centre 255 else 0, window centre 37 else 200 -> pix_out=37.
REQ-033 3x3 all-ones kernel, window centre 5 else 0 -> pix_out=1 with KERNEL_CONV_ROUND_EN, 0 without.
REQ-034 kernel_valid with kernel_size=4 -> err=1, win_ready=0; then kernel_valid with size 3, nonzero kernel -> err=0, win_ready=1.
REQ-035 pix_ready held low 10 cycles in OUT -> pix_out/pix_valid unchanged, win_ready=0; window accepted the cycle after pix_ready.
REQ-036 rst asserted in MAC cycle 4 -> next cycle all outputs 0, win_ready=0 until a new kernel_valid.
